// File: rtl/wb_arb.sv
// Write-back arbiter: merges in-order pipeline writes with late long-latency results
// through a small in-order FIFO that has starvation protection and a pending-write scoreboard.
module wb_arb #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_wen,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  output logic        pipe_stall,
  input  logic        lu_valid,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  input  logic [4:0]  qry_rd,
  output logic        qry_hit,
  output logic        rf_wen,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wdata
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  logic [CW-1:0]    r_count;
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [SW-1:0]    r_starve;
  logic [DEPTH-1:0] r_vld;
  logic [4:0]       r_ent_rd   [DEPTH];
  logic [31:0]      r_ent_data [DEPTH];

  logic w_pipe_act;
  logic w_empty;
  logic w_full;
  logic w_head_gnt;
  logic w_pipe_gnt;
  logic w_enq;

  // Arbitration: head wins when the pipe is idle, the FIFO is full, or the head has starved
  always_comb begin
    w_pipe_act = pipe_wen && (pipe_rd != 5'd0);
    w_empty    = (r_count == '0);
    w_full     = (r_count == FULL_CNT);
    w_head_gnt = !rst && !w_empty &&
                 (!w_pipe_act || w_full || (r_starve == STARVE_LIM));
    w_pipe_gnt = !rst && w_pipe_act && !w_head_gnt;
    lu_ready   = !rst && (r_count < FULL_CNT);
    w_enq      = lu_valid && lu_ready && (lu_rd != 5'd0);
    pipe_stall = w_pipe_act && w_head_gnt;
  end

  // Scoreboard lookup over all live entries
  always_comb begin
    qry_hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (r_vld[PW'(i)] && (r_ent_rd[PW'(i)] == qry_rd)) qry_hit = 1'b1;
    end
    if (rst || (qry_rd == 5'd0)) qry_hit = 1'b0;
  end

  // Entry payload storage needs no reset; validity is tracked by r_vld
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_ent_rd[r_wptr]   <= lu_rd;
      r_ent_data[r_wptr] <= lu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_starve <= '0;
      r_vld    <= '0;
      rf_wen   <= 1'b0;
      rf_rd    <= 5'd0;
      rf_wdata <= 32'd0;
    end else begin
      if (w_head_gnt) begin
        r_vld[r_rptr] <= 1'b0;
        r_rptr        <= r_rptr + PW'(1);
      end
      // Full blocks enqueue via lu_ready, so enq and deq never target the same slot
      if (w_enq) begin
        r_vld[r_wptr] <= 1'b1;
        r_wptr        <= r_wptr + PW'(1);
      end
      r_count <= r_count + CW'(w_enq) - CW'(w_head_gnt);

      if (w_empty || w_head_gnt) begin
        r_starve <= '0;
      end else if (r_starve != STARVE_LIM) begin
        r_starve <= r_starve + SW'(1);
      end

      if (w_head_gnt) begin
        rf_wen   <= 1'b1;
        rf_rd    <= r_ent_rd[r_rptr];
        rf_wdata <= r_ent_data[r_rptr];
      end else if (w_pipe_gnt) begin
        rf_wen   <= 1'b1;
        rf_rd    <= pipe_rd;
        rf_wdata <= pipe_data;
      end else begin
        rf_wen   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_arb.sv
// Bench for wb_arb: directed scenarios then random traffic, all checked against a
// queue-based reference model of the arbitration rules.
module tb_wb_arb;

  localparam int unsigned DEPTH      = 2;
  localparam int unsigned STARVE_MAX = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_wen;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        pipe_stall;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic [4:0]  qry_rd;
  logic        qry_hit;
  logic        rf_wen;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;

  wb_arb #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .pipe_wen(pipe_wen), .pipe_rd(pipe_rd), .pipe_data(pipe_data), .pipe_stall(pipe_stall),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
    .qry_rd(qry_rd), .qry_hit(qry_hit),
    .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        m_q[$];
  int          m_starve;
  logic        m_rf_wen;
  logic [4:0]  m_rf_rd;
  logic [31:0] m_rf_wdata;

  int n_assert = 0;
  int n_fail   = 0;

  logic obs_stall, obs_ready, obs_hit;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: predict and check combinational outputs, advance model, check registered outputs
  task automatic step();
    logic pipe_act, head, ready, stall, hit;
    int   cnt;
    cnt      = m_q.size();
    pipe_act = pipe_wen && (pipe_rd != 0);
    head     = !rst && cnt > 0 && (!pipe_act || cnt == DEPTH || m_starve == STARVE_MAX);
    ready    = !rst && cnt < DEPTH;
    stall    = pipe_act && head;
    hit      = 1'b0;
    if (!rst && qry_rd != 0)
      foreach (m_q[i]) if (m_q[i].rd == qry_rd) hit = 1'b1;
    #1;
    obs_stall = pipe_stall;
    obs_ready = lu_ready;
    obs_hit   = qry_hit;
    check("lu_ready",   32'(lu_ready),   32'(ready));
    check("pipe_stall", 32'(pipe_stall), 32'(stall));
    check("qry_hit",    32'(qry_hit),    32'(hit));
    @(posedge clk);
    if (rst) begin
      m_q.delete();
      m_starve   = 0;
      m_rf_wen   = 1'b0;
      m_rf_rd    = 5'd0;
      m_rf_wdata = 32'd0;
    end else begin
      if (head) begin
        ent_t e;
        e          = m_q.pop_front();
        m_rf_wen   = 1'b1;
        m_rf_rd    = e.rd;
        m_rf_wdata = e.data;
        m_starve   = 0;
      end else begin
        if (pipe_act) begin
          m_rf_wen   = 1'b1;
          m_rf_rd    = pipe_rd;
          m_rf_wdata = pipe_data;
        end else begin
          m_rf_wen = 1'b0;
        end
        if (cnt == 0) m_starve = 0;
        else if (m_starve < STARVE_MAX) m_starve++;
      end
      if (lu_valid && ready && lu_rd != 0) m_q.push_back('{rd: lu_rd, data: lu_data});
    end
    #1;
    check("rf_wen",   32'(rf_wen),   32'(m_rf_wen));
    check("rf_rd",    32'(rf_rd),    32'(m_rf_rd));
    check("rf_wdata", rf_wdata,      m_rf_wdata);
    if (rf_wen) check("rf_no_x0", 32'(rf_rd != 0), 32'd1);
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b0; pipe_wen = 1'b0; pipe_rd = 5'd0; pipe_data = 32'd0;
    lu_valid = 1'b0; lu_rd = 5'd0; lu_data = 32'd0; qry_rd = 5'd0;
  endtask

  task automatic drain();
    idle();
    for (int k = 0; k < 16 && m_q.size() != 0; k++) step();
    check("drain_empty", 32'(m_q.size()), 32'd0);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    m_starve = 0; m_rf_wen = 1'b0; m_rf_rd = 5'd0; m_rf_wdata = 32'd0;
    @(negedge clk);
    step();
    step();
    check("rst_rf_wen", 32'(rf_wen), 32'd0);
    check("rst_ready",  32'(obs_ready), 32'd0);

    // Plain pipe write with empty FIFO
    idle();
    pipe_wen = 1'b1; pipe_rd = 5'd5; pipe_data = 32'hDEAD_BEEF;
    step();
    check("p_stall", 32'(obs_stall), 32'd0);
    check("p_rd",    32'(rf_rd), 32'd5);
    check("p_data",  rf_wdata, 32'hDEAD_BEEF);

    // Late result with idle pipe; scoreboard hit until retire
    idle();
    lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'h1234;
    step();
    idle(); qry_rd = 5'd7;
    step();
    check("lu_hit", 32'(obs_hit), 32'd1);
    check("lu_rd_wr", 32'(rf_rd), 32'd7);
    step();
    check("lu_hit_gone", 32'(obs_hit), 32'd0);

    // Full FIFO forces head through a busy pipe
    idle();
    pipe_wen = 1'b1; pipe_rd = 5'd10; pipe_data = 32'hA;
    lu_valid = 1'b1; lu_rd = 5'd3; lu_data = 32'h33;
    step();
    pipe_rd = 5'd11; lu_rd = 5'd4; lu_data = 32'h44;
    step();
    pipe_rd = 5'd12; lu_rd = 5'd9; lu_data = 32'h99;
    step();
    check("full_ready", 32'(obs_ready), 32'd0);
    check("full_stall", 32'(obs_stall), 32'd1);
    check("full_rd3",   32'(rf_rd), 32'd3);
    lu_valid = 1'b0;
    step();
    check("full_stall_once", 32'(obs_stall), 32'd0);
    drain();

    // Starvation limit with pipe active every cycle
    idle();
    pipe_wen = 1'b1; pipe_rd = 5'd20; pipe_data = 32'h20;
    lu_valid = 1'b1; lu_rd = 5'd6; lu_data = 32'h66;
    step();
    lu_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("starve_pipe", 32'(obs_stall), 32'd0);
    end
    lu_valid = 1'b1; lu_rd = 5'd8; lu_data = 32'h88;
    step();
    check("starve_force", 32'(obs_stall), 32'd1);
    check("starve_rd6",   32'(rf_rd), 32'd6);
    lu_valid = 1'b0;
    step();
    check("starve_reset", 32'(obs_stall), 32'd0);
    drain();

    // x0 traffic is swallowed on both sides
    idle();
    pipe_wen = 1'b1; lu_valid = 1'b1; lu_data = 32'h5A5A;
    step();
    check("x0_wen", 32'(rf_wen), 32'd0);
    idle();
    step();
    check("x0_ready", 32'(obs_ready), 32'd1);
    check("x0_wen2",  32'(rf_wen), 32'd0);

    // Reset with two entries pending
    idle();
    pipe_wen = 1'b1; pipe_rd = 5'd1; pipe_data = 32'h1;
    lu_valid = 1'b1; lu_rd = 5'd13; lu_data = 32'hD;
    step();
    lu_rd = 5'd14; lu_data = 32'hE;
    step();
    idle(); rst = 1'b1; qry_rd = 5'd13;
    step();
    check("rst_hit", 32'(obs_hit), 32'd0);
    check("rst_wen", 32'(rf_wen), 32'd0);
    idle(); qry_rd = 5'd14;
    step();
    check("post_rst_hit",   32'(obs_hit), 32'd0);
    check("post_rst_ready", 32'(obs_ready), 32'd1);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 59) == 0);
      pipe_wen  = ($urandom_range(0, 3) != 0);
      pipe_rd   = 5'($urandom_range(0, 7));
      pipe_data = $urandom;
      lu_valid  = ($urandom_range(0, 1) == 1);
      lu_rd     = 5'($urandom_range(0, 7));
      lu_data   = $urandom;
      qry_rd    = 5'($urandom_range(0, 7));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
